alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational ALU, with the same 3-bit opcode set.
- Adds configurable width, valid/ready handshakes on input and output, and a registered status-flag word (C/Z/N/V).
- Shifts are multi-bit and iterative, one bit per cycle.
- Sits between the datapath register file and the writeback stage of the lab CPU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states
// and the packed status-flag word.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] ALU_ADD    = 3'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB    = 3'd1;
  localparam logic [FUNC_W-1:0] ALU_ASSIGN = 3'd2;
  localparam logic [FUNC_W-1:0] ALU_LSHIFT = 3'd3;
  localparam logic [FUNC_W-1:0] ALU_RSHIFT = 3'd4;
  localparam logic [FUNC_W-1:0] ALU_AND    = 3'd5;
  localparam logic [FUNC_W-1:0] ALU_NOT    = 3'd6;
  localparam logic [FUNC_W-1:0] ALU_OR     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  function automatic logic is_shift(input logic [FUNC_W-1:0] f);
    return (f == ALU_LSHIFT) || (f == ALU_RSHIFT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU operations with carry/overflow generation.
// Ports:
//   func     - opcode
//   in1/in2  - operands
//   cin      - carry in for ADD/SUB
//   result_c - combinational result (shift opcodes pass in1 through)
//   cout_c   - carry out (ADD/SUB only, else 0)
//   ovf_c    - signed overflow (ADD/SUB only, else 0)
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic              cin,
  output logic [WIDTH-1:0]  result_c,
  output logic              cout_c,
  output logic              ovf_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Subtraction is addition of the inverted operand; cin=1 completes two's complement.
  assign sum  = {1'b0, in1} + {1'b0, in2}  + (WIDTH+1)'(cin);
  assign diff = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(cin);

  // Opcode decode
  always_comb begin
    result_c = in1;
    cout_c   = 1'b0;
    ovf_c    = 1'b0;
    case (func)
      ALU_ADD: begin
        result_c = sum[WIDTH-1:0];
        cout_c   = sum[WIDTH];
        ovf_c    = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
      end
      ALU_SUB: begin
        result_c = diff[WIDTH-1:0];
        cout_c   = diff[WIDTH];
        ovf_c    = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
      end
      ALU_ASSIGN: result_c = in2;
      ALU_AND:    result_c = in1 & in2;
      ALU_NOT:    result_c = ~in1;
      ALU_OR:     result_c = in1 | in2;
      default:    result_c = in1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and iterative one-bit-per-cycle
// logical shifts.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   in_valid/in_ready       - operation request handshake
//   func, in1, in2, Cin     - opcode, operands, carry in
//   out_valid/out_ready     - result handshake
//   result                  - registered result
//   Cout, zero, neg, ovf    - registered status flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        func,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic              Cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              Cout,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned MSB     = WIDTH - 1;

  state_t               state_q,     state_d;
  logic [WIDTH-1:0]     result_q,    result_d;
  flags_t               flags_q,     flags_d;
  logic [SHAMT_W-1:0]   cnt_q,       cnt_d;
  logic                 dir_q,       dir_d;      // 1 = right shift
  logic                 out_valid_q, out_valid_d;
  logic                 started_q;                // holds in_ready low until first edge out of reset

  logic [WIDTH-1:0]     core_result;
  logic                 core_cout;
  logic                 core_ovf;
  logic                 accept;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     shifted;
  logic                 shift_out;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .func     (func),
    .in1      (in1),
    .in2      (in2),
    .cin      (Cin),
    .result_c (core_result),
    .cout_c   (core_cout),
    .ovf_c    (core_ovf)
  );

  assign in_ready = started_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = in2[SHAMT_W-1:0];

  // One-bit logical shift of the working result, zero fill
  assign shifted   = dir_q ? {1'b0, result_q[WIDTH-1:1]} : {result_q[WIDTH-2:0], 1'b0};
  assign shift_out = dir_q ? result_q[0] : result_q[MSB];

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        result_d      = shifted;
        flags_d.cout  = shift_out;
        flags_d.zero  = (shifted == '0);
        flags_d.neg   = shifted[MSB];
        cnt_d         = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Acceptance only happens from IDLE or a draining DONE, so it overrides the above
    if (accept) begin
      if (is_shift(func)) begin
        result_d     = in1;
        cnt_d        = shamt;
        dir_d        = (func == ALU_RSHIFT);
        flags_d.cout = 1'b0;
        flags_d.ovf  = 1'b0;
        flags_d.zero = (in1 == '0);
        flags_d.neg  = in1[MSB];
        if (shamt != '0) begin
          state_d     = ST_SHIFT;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end else begin
        result_d     = core_result;
        flags_d.cout = core_cout;
        flags_d.ovf  = core_ovf;
        flags_d.zero = (core_result == '0);
        flags_d.neg  = core_result[MSB];
        state_d      = ST_DONE;
        out_valid_d  = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      out_valid_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      out_valid_q <= out_valid_d;
      started_q   <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an 8-bit and a 16-bit instance checked against a
// plain-arithmetic reference model with directed and random operations.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv8, ir8, c8, ov8, ordy8, co8, z8, n8, v8;
  logic [2:0]  f8;
  logic [7:0]  a8, b8, r8;
  logic        iv16, ir16, c16, ov16, ordy16, co16, z16, n16, v16;
  logic [2:0]  f16;
  logic [15:0] a16, b16, r16;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .func(f8),
    .in1(a8), .in2(b8), .Cin(c8), .out_valid(ov8), .out_ready(ordy8),
    .result(r8), .Cout(co8), .zero(z8), .neg(n8), .ovf(v8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .func(f16),
    .in1(a16), .in2(b16), .Cin(c16), .out_valid(ov16), .out_ready(ordy16),
    .result(r16), .Cout(co16), .zero(z16), .neg(n16), .ovf(v16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, out_valid, Cout, zero, neg, ovf}
  function automatic logic [5:0] sts(input bit sel);
    return sel ? {ir16, ov16, co16, z16, n16, v16} : {ir8, ov8, co8, z8, n8, v8};
  endfunction

  function automatic logic [63:0] res(input bit sel);
    return sel ? 64'(r16) : 64'(r8);
  endfunction

  task automatic drive(input bit sel, input logic iv, input int f, input logic [63:0] a,
                       input logic [63:0] b, input logic c, input logic ordy);
    if (sel) begin
      iv16 = iv; f16 = 3'(f); a16 = a[15:0]; b16 = b[15:0]; c16 = c; ordy16 = ordy;
    end else begin
      iv8 = iv; f8 = 3'(f); a8 = a[7:0]; b8 = b[7:0]; c8 = c; ordy8 = ordy;
    end
  endtask

  // Reference model straight from the opcode definitions
  function automatic void model(input int w, input int f, input logic [63:0] a, input logic [63:0] b,
                                input logic c, output logic [63:0] r, output logic co,
                                output logic z, output logic ng, output logic v, output int lat);
    logic [63:0] mask, s;
    int n;
    mask = (64'd1 << w) - 64'd1;
    n    = int'(b & 64'(w - 1));
    s = '0; co = 1'b0; v = 1'b0; lat = 1; r = '0;
    case (f)
      0: begin
        s = a + b + 64'(c); r = s & mask; co = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      1: begin
        s = a + (~b & mask) + 64'(c); r = s & mask; co = s[w];
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      2: r = b;
      3: begin r = (a << n) & mask; co = (n > 0) ? a[w-n] : 1'b0; lat = 1 + n; end
      4: begin r = a >> n;          co = (n > 0) ? a[n-1] : 1'b0; lat = 1 + n; end
      5: r = a & b;
      6: r = ~a & mask;
      default: r = a | b;
    endcase
    z  = (r == 64'd0);
    ng = r[w-1];
  endfunction

  // Issue one operation, measure latency, check result/flags, optionally stall the consumer
  task automatic do_op(input bit sel, input int f, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input int stall);
    logic [63:0] er;
    logic eco, ez, en, ev;
    int elat, lat, w;
    logic [5:0] s;
    w = sel ? 16 : 8;
    model(w, f, a, b, c, er, eco, ez, en, ev, elat);
    @(negedge clk);
    drive(sel, 1'b1, f, a, b, c, stall == 0);
    s = sts(sel);
    check("in_ready_idle", 64'(s[5]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, f, a, b, c, stall == 0);
    lat = 1;
    s = sts(sel);
    while (!s[4] && lat < 64) begin
      check("in_ready_busy", 64'(s[5]), 64'd0);
      @(negedge clk);
      lat++;
      s = sts(sel);
    end
    check("latency", 64'(lat), 64'(elat));
    check("result", res(sel), er);
    check("cout", 64'(s[3]), 64'(eco));
    check("zero", 64'(s[2]), 64'(ez));
    check("neg", 64'(s[1]), 64'(en));
    check("ovf", 64'(s[0]), 64'(ev));
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      s = sts(sel);
      check("hold_valid", 64'(s[4]), 64'd1);
      check("hold_ready", 64'(s[5]), 64'd0);
      check("hold_result", res(sel), er);
    end
    if (stall > 0) drive(sel, 1'b0, f, a, b, c, 1'b1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int rf, rs;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    #12;
    check("rst_ready8", 64'(ir8), 64'd0);
    check("rst_status8", 64'(sts(1'b0)), 64'd0);
    check("rst_result8", 64'(r8), 64'd0);
    check("rst_status16", 64'(sts(1'b1)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst8", 64'(ir8), 64'd1);
    check("ready_after_rst16", 64'(ir16), 64'd1);

    // Directed 8-bit cases
    do_op(1'b0, ALU_ADD,    200,   100, 1'b0, 0);
    do_op(1'b0, ALU_SUB,    5,     5,   1'b1, 0);
    do_op(1'b0, ALU_ADD,    127,   1,   1'b0, 0);
    do_op(1'b0, ALU_LSHIFT, 8'h81, 3,   1'b0, 0);
    do_op(1'b0, ALU_RSHIFT, 8'h81, 1,   1'b0, 0);
    do_op(1'b0, ALU_RSHIFT, 8'h81, 0,   1'b0, 0);
    do_op(1'b0, ALU_SUB,    3,     5,   1'b1, 2);

    // Backpressure, then a back-to-back issue on the draining cycle
    @(negedge clk);
    drive(1'b0, 1'b1, ALU_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, ALU_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 64'(ov8), 64'd1);
      check("bp_result", 64'(r8), 64'h30);
      check("bp_ready", 64'(ir8), 64'd0);
    end
    drive(1'b0, 1'b1, ALU_OR, 8'h01, 8'h02, 1'b0, 1'b1);
    #1;
    check("b2b_ready", 64'(ir8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, ALU_OR, 8'h01, 8'h02, 1'b0, 1'b1);
    check("b2b_valid", 64'(ov8), 64'd1);
    check("b2b_result", 64'(r8), 64'h03);

    // Reset in the middle of a long shift
    @(negedge clk);
    drive(1'b0, 1'b1, ALU_LSHIFT, 8'h5A, 7, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, ALU_LSHIFT, 8'h5A, 7, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_status", 64'(sts(1'b0)), 64'd0);
    check("abort_result", 64'(r8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(ir8), 64'd1);
    do_op(1'b0, ALU_ADD, 8'h12, 8'h34, 1'b1, 0);

    // Random 8-bit operations with random consumer stalls
    for (int k = 0; k < 60; k++) begin
      rf = int'($urandom_range(0, 7));
      ra = 64'($urandom) & 64'hFF;
      rb = 64'($urandom) & 64'hFF;
      rs = int'($urandom_range(0, 3));
      do_op(1'b0, rf, ra, rb, 1'($urandom), rs);
    end

    // 16-bit regression
    do_op(1'b1, ALU_ADD,    16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(1'b1, ALU_LSHIFT, 16'h0003, 15,       1'b0, 0);
    for (int k = 0; k < 12; k++) begin
      rf = int'($urandom_range(0, 7));
      ra = 64'($urandom) & 64'hFFFF;
      rb = 64'($urandom) & 64'hFFFF;
      do_op(1'b1, rf, ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
